fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of the decode `controller`. It does four things:
- holds the fetch PC and issues in-order requests to instruction memory over a request/grant bus;
- buffers returned words in a small FIFO;
- presents them to decode with a valid/ready handshake, together with pre-sliced opcode, funct3 and funct7 fields;
- on a branch/jump redirect, flushes the FIFO and discards responses still in flight, then restarts from the new PC.

## Interface
Parameters:
- RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, default 4: instruction buffer entries; power of 2, ≥2. This is also the cap on outstanding requests plus buffered words.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- o_imem_req  out  1  request valid.
- o_imem_addr  out  32  request address (word aligned).
- i_imem_gnt  in  1  request accepted this cycle; counts only when o_imem_req=1.
- i_imem_rvalid  in  1  response valid; exactly one per grant, in order, no earlier than the cycle after its grant.
- i_imem_rdata  in  32  response word.
- i_redirect  in  1  taken branch/jump from execute.
- i_redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- o_instr_valid  out  1  FIFO head valid.
- i_instr_ready  in  1  decode accepts the head this cycle.
- o_instr  out  32  head instruction word.
- o_pc  out  32  PC of the head instruction.
- o_opcode  out  opcodeType  o_instr[6:0].
- o_funct3  out  3  o_instr[14:12].
- o_funct7  out  7  o_instr[31:25].

## Operation
State machine:
- BOOT: entered on reset. No request is issued. Moves to RUN on the first clock edge after reset is released.
- RUN: steady state.

Registers:
- fetch_pc
- outstanding: granted requests not yet responded to, 0..FIFO_DEPTH.
- count: FIFO occupancy, 0..FIFO_DEPTH.
- drop: stale responses still to discard, 0..FIFO_DEPTH.
- FIFO storage of {pc, instr}.

Request side:
- In RUN, o_imem_req = (outstanding + count < FIFO_DEPTH) && !i_redirect.
- o_imem_addr = fetch_pc.
- On req && gnt: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC → 0) and outstanding += 1.

Response side:
- Each rvalid decrements outstanding.
- If drop > 0 at the time: the word is discarded and drop -= 1.
- Otherwise {pc, rdata} is pushed into the FIFO. The pc is tracked by a separate resp_pc register that advances by 4 on each push.

Consumer side:
- o_instr_valid = (count != 0).
- A pop happens when o_instr_valid && i_instr_ready.
- Push and pop in the same cycle leave count unchanged.
- The credit rule makes a push into a full FIFO impossible. Verification must assert this.

Redirect (i_redirect=1):
- Takes priority over every other event in that cycle.
- fetch_pc ← {i_redirect_pc[31:2],2'b00}, and resp_pc is set to the same value.
- FIFO is flushed: count ← 0; any pop in that cycle is ignored.
- drop ← outstanding − (rvalid ? 1 : 0). No grant is possible that cycle, since req is deasserted.
- A response arriving in the redirect cycle is discarded.
- New requests may issue from the next cycle while drop > 0; ordering guarantees the stale words arrive first.

Outputs when o_instr_valid=0: o_instr, o_pc, o_opcode, o_funct3 and o_funct7 are all 0.

## Timing
Reset values (asynchronous):
- state = BOOT; fetch_pc = resp_pc = RESET_PC.
- outstanding = count = drop = 0.
- o_imem_req=0, o_imem_addr=RESET_PC, o_instr_valid=0, o_instr=0, o_pc=0.

Latency:
- First request is issued in the 2nd cycle after reset deasserts.
- An rvalid in cycle N is visible as o_instr_valid in cycle N+1 (FIFO write is registered).
- Redirect in cycle N: o_instr_valid=0 in cycle N+1; the request for the new PC goes out in cycle N+1.

Throughput and back-pressure:
- With the default FIFO_DEPTH=4, a memory with 1-cycle grant-to-response latency and i_instr_ready held high, the block sustains 1 instruction per cycle.
- With i_instr_ready low, requests stop once outstanding + count = FIFO_DEPTH; the head is held stable.
- Reset asserted mid-operation discards all state immediately. Any responses that arrive later are memory-side protocol violations; the memory must also be reset.

## Test plan
- Reset, then gnt always 1, 1-cycle rvalid, ready=1 → addresses 0,4,8,... one per cycle; o_pc/o_instr stream in order with no bubbles after the first.
- ready=0 for 10 cycles → exactly 4 requests outstanding-or-buffered, req low afterwards; head stable at pc=0; all 4 drain in order after ready=1.
- Redirect to 32'h0000_0103 with 2 responses in flight → both are discarded; next o_pc=32'h0000_0100; o_instr_valid=0 in the cycle after the redirect.
- Redirect coincident with rvalid and ready=1 → that word is neither pushed nor popped; drop = outstanding−1.
- Random gnt stalls and random 1–3 cycle response latency, 1000 instructions → output stream equals the memory image in PC order; the no-push-when-full assertion never fires.
- Fetch near 32'hFFFF_FFF8 → addresses wrap FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request/grant fetch, in-order response FIFO,
// valid/ready handoff to decode, and redirect handling that drops stale in-flight words.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [CW:0]   DEPTH_W = FIFO_DEPTH[CW:0];
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [0:0]    state_r;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] drop_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [31:0]   pc_mem_r    [FIFO_DEPTH];
    logic [31:0]   instr_mem_r [FIFO_DEPTH];

    logic [CW:0]   credit_s;
    logic          req_s;
    logic          grant_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [31:0]   redirect_pc_s;
    logic [31:0]   head_instr_s;
    logic [31:0]   head_pc_s;
    logic [CW-1:0] grant_c_s;
    logic [CW-1:0] rvalid_c_s;
    logic [CW-1:0] push_c_s;
    logic [CW-1:0] pop_c_s;

    // Handshake qualifiers; a redirect masks request, push and pop in its cycle.
    always_comb begin
        credit_s      = {1'b0, outstanding_r} + {1'b0, count_r};
        valid_s       = (count_r != ZERO_C);
        req_s         = (state_r == ST_RUN) && (credit_s < DEPTH_W) && !i_redirect;
        grant_s       = req_s && i_imem_gnt;
        push_s        = i_imem_rvalid && (drop_r == ZERO_C) && !i_redirect;
        pop_s         = valid_s && i_instr_ready && !i_redirect;
        redirect_pc_s = {i_redirect_pc[31:2], 2'b00};
        grant_c_s     = {{AW{1'b0}}, grant_s};
        rvalid_c_s    = {{AW{1'b0}}, i_imem_rvalid};
        push_c_s      = {{AW{1'b0}}, push_s};
        pop_c_s       = {{AW{1'b0}}, pop_s};
        head_instr_s  = valid_s ? instr_mem_r[head_r] : 32'h0000_0000;
        head_pc_s     = valid_s ? pc_mem_r[head_r]    : 32'h0000_0000;
    end

    // Control state: FSM, PCs, credit counters and FIFO pointers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= ST_BOOT;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= ZERO_C;
            count_r       <= ZERO_C;
            drop_r        <= ZERO_C;
            head_r        <= {AW{1'b0}};
            tail_r        <= {AW{1'b0}};
        end else begin
            state_r       <= ST_RUN;
            outstanding_r <= outstanding_r + grant_c_s - rvalid_c_s;
            if (i_redirect) begin
                fetch_pc_r <= redirect_pc_s;
                resp_pc_r  <= redirect_pc_s;
                count_r    <= ZERO_C;
                drop_r     <= outstanding_r - rvalid_c_s;
                head_r     <= {AW{1'b0}};
                tail_r     <= {AW{1'b0}};
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + 32'd4;
                    tail_r    <= tail_r + {{(AW-1){1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    head_r <= head_r + {{(AW-1){1'b0}}, 1'b1};
                end
                // Stale words are those granted before the redirect; they arrive first.
                if (i_imem_rvalid && (drop_r != ZERO_C)) begin
                    drop_r <= drop_r - {{AW{1'b0}}, 1'b1};
                end
                count_r <= count_r + push_c_s - pop_c_s;
            end
        end
    end

    // FIFO storage; contents are only observed through the count-qualified head.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]    <= resp_pc_r;
            instr_mem_r[tail_r] <= i_imem_rdata;
        end
    end

    assign o_imem_req    = req_s;
    assign o_imem_addr   = fetch_pc_r;
    assign o_instr_valid = valid_s;
    assign o_instr       = head_instr_s;
    assign o_pc          = head_pc_s;
    assign o_opcode      = head_instr_s[6:0];
    assign o_funct3      = head_instr_s[14:12];
    assign o_funct7      = head_instr_s[31:25];

endmodule
